// File: rtl/lzd_denorm_48.sv
// -----------------------------------------------------------------------------
// lzd_denorm_48
//
// Purpose
//   Undoes leading-zero normalization. The mantissa arrives left-aligned (MSB
//   set) together with the leading-zero count produced by the 48-bit LZD. The
//   block right-shifts it by that count to restore the fixed-point scaling.
//   The shift is split across three pipeline stages:
//     stage 1 : shift by cnt[5:4] * 16  (0/16/32/48)
//     stage 2 : shift by cnt[3:2] * 4   (0/4/8/12)
//     stage 3 : shift by cnt[1:0]       (0..3), optional rounding, output regs
//   Every bit shifted out is ORed into a sticky (inexact) flag.
//
// Configuration
//   LZD_DENORM_ROUND_EN : when defined, stage 3 applies round-to-nearest-even
//                         using a separately tracked guard bit. When undefined
//                         the result is truncated, and only a single combined
//                         sticky bit is carried down the pipe.
//
// Parameters
//   W  : data width, fixed at 48 (the shift slices below assume 48)
//   CW : shift-count width (6)
//
// Ports
//   clk         in   system clock, rising edge
//   reset       in   asynchronous active-high reset
//   in_valid    in   upstream word present
//   in_ready    out  block accepts a word this cycle
//   in_mant     in   normalized mantissa
//   in_cnt      in   right-shift amount 0..63
//   in_nz       in   LZD valid flag; 0 means the original value was zero
//   out_valid   out  output word present
//   out_ready   in   downstream accepts the word
//   out_data    out  denormalized result
//   out_sticky  out  OR of every bit shifted out (pre-round inexactness)
//   out_zero    out  result is exactly zero
//
// Handshake: a word moves across an interface on a rising clk edge where that
// interface has valid && ready. A stage register loads when it is empty or
// its successor is loading this cycle, so ready propagates combinationally
// from out_ready back to in_ready and a full pipe streams one word per cycle.
// While out_valid is high and out_ready low the output registers hold.
// -----------------------------------------------------------------------------
module lzd_denorm_48 #(
  parameter int W  = 48,
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_mant,
  input  logic [CW-1:0] in_cnt,
  input  logic          in_nz,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic          out_sticky,
  output logic          out_zero
);

  // Shift result: data, the bit just below the data LSB (guard), and the OR of
  // everything further below (below).
  typedef struct packed {
    logic [47:0] d;
    logic        g;
    logic        b;
  } sh_t;

  // Coarse shift by sel*16 straight from the input (nothing shifted out yet).
  function automatic sh_t shift16(input logic [47:0] m, input logic [1:0] sel);
    sh_t r;
    r = '0;
    case (sel)
      2'd0: begin r.d = m;                    r.g = 1'b0;   r.b = 1'b0;      end
      2'd1: begin r.d = {16'b0, m[47:16]};    r.g = m[15];  r.b = |m[14:0];  end
      2'd2: begin r.d = {32'b0, m[47:32]};    r.g = m[31];  r.b = |m[30:0];  end
      default: begin r.d = '0;                r.g = m[47];  r.b = |m[46:0];  end
    endcase
    return r;
  endfunction

  // Middle shift by sel*4. The old guard drops into 'below' once anything
  // further is shifted out.
  function automatic sh_t shift4(input sh_t x, input logic [1:0] sel);
    sh_t r;
    r = x;
    case (sel)
      2'd0: r = x;
      2'd1: begin r.d = {4'b0,  x.d[47:4]};  r.g = x.d[3];  r.b = x.b | x.g | (|x.d[2:0]);  end
      2'd2: begin r.d = {8'b0,  x.d[47:8]};  r.g = x.d[7];  r.b = x.b | x.g | (|x.d[6:0]);  end
      default: begin r.d = {12'b0, x.d[47:12]}; r.g = x.d[11]; r.b = x.b | x.g | (|x.d[10:0]); end
    endcase
    return r;
  endfunction

  // Fine shift by sel (0..3).
  function automatic sh_t shift1(input sh_t x, input logic [1:0] sel);
    sh_t r;
    r = x;
    case (sel)
      2'd0: r = x;
      2'd1: begin r.d = {1'b0, x.d[47:1]}; r.g = x.d[0]; r.b = x.b | x.g;                  end
      2'd2: begin r.d = {2'b0, x.d[47:2]}; r.g = x.d[1]; r.b = x.b | x.g | x.d[0];         end
      default: begin r.d = {3'b0, x.d[47:3]}; r.g = x.d[2]; r.b = x.b | x.g | (|x.d[1:0]); end
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Pipeline registers
  // ---------------------------------------------------------------------------
  logic        s1_valid_q, s1_valid_d;
  logic [47:0] s1_data_q,  s1_data_d;
  logic        s1_sticky_q, s1_sticky_d;
  logic [3:0]  s1_cnt_q,   s1_cnt_d;
  logic        s1_zero_q,  s1_zero_d;

  logic        s2_valid_q, s2_valid_d;
  logic [47:0] s2_data_q,  s2_data_d;
  logic        s2_sticky_q, s2_sticky_d;
  logic [1:0]  s2_cnt_q,   s2_cnt_d;
  logic        s2_zero_q,  s2_zero_d;

`ifdef LZD_DENORM_ROUND_EN
  // Guard bits travel separately so stage 3 can round; the *_sticky_q
  // registers then hold only the bits below the guard.
  logic        s1_guard_q, s1_guard_d;
  logic        s2_guard_q, s2_guard_d;
`endif

  logic        out_valid_q,  out_valid_d;
  logic [47:0] out_data_q,   out_data_d;
  logic        out_sticky_q, out_sticky_d;
  logic        out_zero_q,   out_zero_d;

  // ---------------------------------------------------------------------------
  // Flow control
  // ---------------------------------------------------------------------------
  logic load3, load2, load1;

  assign load3    = ~out_valid_q | out_ready;
  assign load2    = ~s2_valid_q  | load3;
  assign load1    = ~s1_valid_q  | load2;
  assign in_ready = load1;

  // ---------------------------------------------------------------------------
  // Stage 1: coarse shift
  // ---------------------------------------------------------------------------
  sh_t st1;

  always_comb begin
    st1         = shift16(in_mant, in_cnt[5:4]);
    s1_valid_d  = in_valid;
    s1_cnt_d    = in_cnt[3:0];
    s1_zero_d   = ~in_nz;
    s1_data_d   = in_nz ? st1.d : '0;
`ifdef LZD_DENORM_ROUND_EN
    s1_guard_d  = in_nz & st1.g;
    s1_sticky_d = in_nz & st1.b;
`else
    s1_sticky_d = in_nz & (st1.g | st1.b);
`endif
  end

  // ---------------------------------------------------------------------------
  // Stage 2: middle shift
  // ---------------------------------------------------------------------------
  sh_t st2_in, st2;

  always_comb begin
    st2_in.d    = s1_data_q;
`ifdef LZD_DENORM_ROUND_EN
    st2_in.g    = s1_guard_q;
`else
    // With a single combined sticky, feeding it in as 'below' with a zero
    // guard gives the same OR of dropped bits.
    st2_in.g    = 1'b0;
`endif
    st2_in.b    = s1_sticky_q;
    st2         = shift4(st2_in, s1_cnt_q[3:2]);
    s2_valid_d  = s1_valid_q;
    s2_cnt_d    = s1_cnt_q[1:0];
    s2_zero_d   = s1_zero_q;
    s2_data_d   = st2.d;
`ifdef LZD_DENORM_ROUND_EN
    s2_guard_d  = st2.g;
    s2_sticky_d = st2.b;
`else
    s2_sticky_d = st2.g | st2.b;
`endif
  end

  // ---------------------------------------------------------------------------
  // Stage 3: fine shift, optional rounding, output
  // ---------------------------------------------------------------------------
  sh_t         st3_in, st3;
  logic [47:0] result;

  always_comb begin
    st3_in.d = s2_data_q;
`ifdef LZD_DENORM_ROUND_EN
    st3_in.g = s2_guard_q;
`else
    st3_in.g = 1'b0;
`endif
    st3_in.b = s2_sticky_q;
    st3      = shift1(st3_in, s2_cnt_q);
    result   = st3.d;
`ifdef LZD_DENORM_ROUND_EN
    // Nearest-even: round up above the halfway point, or exactly at it when
    // the LSB is odd. A carry out of bit 47 is impossible for cnt >= 1, but
    // saturate rather than wrap in case it ever happens.
    if (st3.g & (st3.b | st3.d[0])) begin
      result = (&st3.d) ? st3.d : st3.d + 48'd1;
    end
`endif
    out_valid_d  = s2_valid_q;
    out_data_d   = result;
    out_sticky_d = st3.g | st3.b;
    out_zero_d   = s2_zero_q | (result == 48'd0);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_sticky_q <= 1'b0;
      s1_cnt_q    <= '0;
      s1_zero_q   <= 1'b0;
`ifdef LZD_DENORM_ROUND_EN
      s1_guard_q  <= 1'b0;
`endif
    end else if (load1) begin
      s1_valid_q <= s1_valid_d;
      if (in_valid) begin
        s1_data_q   <= s1_data_d;
        s1_sticky_q <= s1_sticky_d;
        s1_cnt_q    <= s1_cnt_d;
        s1_zero_q   <= s1_zero_d;
`ifdef LZD_DENORM_ROUND_EN
        s1_guard_q  <= s1_guard_d;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid_q  <= 1'b0;
      s2_data_q   <= '0;
      s2_sticky_q <= 1'b0;
      s2_cnt_q    <= '0;
      s2_zero_q   <= 1'b0;
`ifdef LZD_DENORM_ROUND_EN
      s2_guard_q  <= 1'b0;
`endif
    end else if (load2) begin
      s2_valid_q <= s2_valid_d;
      if (s1_valid_q) begin
        s2_data_q   <= s2_data_d;
        s2_sticky_q <= s2_sticky_d;
        s2_cnt_q    <= s2_cnt_d;
        s2_zero_q   <= s2_zero_d;
`ifdef LZD_DENORM_ROUND_EN
        s2_guard_q  <= s2_guard_d;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_sticky_q <= 1'b0;
      out_zero_q   <= 1'b0;
    end else if (load3) begin
      out_valid_q <= out_valid_d;
      // Data registers only change when a real word arrives, so the last
      // result stays visible while the output is idle or stalled.
      if (s2_valid_q) begin
        out_data_q   <= out_data_d;
        out_sticky_q <= out_sticky_d;
        out_zero_q   <= out_zero_d;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_sticky = out_sticky_q;
  assign out_zero   = out_zero_q;

endmodule

// File: tb/tb_lzd_denorm_48.sv
module tb_lzd_denorm_48;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] in_mant;
  logic [5:0]  in_cnt;
  logic        in_nz;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] out_data;
  logic        out_sticky;
  logic        out_zero;

  always #5 clk = ~clk;

  lzd_denorm_48 dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_mant    (in_mant),
    .in_cnt     (in_cnt),
    .in_nz      (in_nz),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sticky (out_sticky),
    .out_zero   (out_zero)
  );

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int chk_cnt = 0;
  int err_cnt = 0;
  int acc_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: place the mantissa at the top of a 96-bit field, shift, and
  // read the result off the top half and the dropped bits off the bottom.
  function automatic logic [49:0] model(input logic [47:0] m, input logic [5:0] c,
                                        input logic nz);
    logic [95:0] full;
    logic [47:0] d;
    logic [47:0] drop;
    logic        st;
    full = {m, 48'b0} >> c;
    d    = full[95:48];
    drop = full[47:0];
    st   = |drop;
`ifdef LZD_DENORM_ROUND_EN
    if (drop[47] && ((|drop[46:0]) || d[0])) begin
      if (d != 48'hFFFF_FFFF_FFFF) d = d + 48'd1;
    end
`endif
    if (!nz) begin
      d  = '0;
      st = 1'b0;
    end
    return {(d == 48'd0), st, d};
  endfunction

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [49:0] exp_q[$];

  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 64'd1, 64'd0);
        end else begin
          check("out_word", {14'b0, out_zero, out_sticky, out_data}, {14'b0, exp_q[0]});
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_mant, in_cnt, in_nz));
        acc_cnt++;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic send(input logic [47:0] m, input logic [5:0] c, input logic z);
    logic acc;
    int   n;
    in_valid = 1'b1;
    in_mant  = m;
    in_cnt   = c;
    in_nz    = z;
    acc      = 1'b0;
    n        = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_left", exp_q.size(), 64'd0);
  endtask

  // One word through an empty pipe, fields checked against literal values.
  task automatic run_one(input string tag, input logic [47:0] m, input logic [5:0] c,
                         input logic z, input logic [47:0] ed, input logic es,
                         input logic ez);
    int n;
    send(m, c, z);
    n = 0;
    while (!out_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_valid"}, out_valid, 64'd1);
    check({tag, "_data"}, out_data, ed);
    check({tag, "_sticky"}, out_sticky, es);
    check({tag, "_zero"}, out_zero, ez);
    wait_drain();
  endtask

  // After send() returns the acceptance edge has passed; out_valid must rise
  // only after the third edge counted from acceptance.
  task automatic latency_probe(input string tag, input logic [47:0] m, input logic [5:0] c);
    send(m, c, 1'b1);
    check({tag, "_e1"}, out_valid, 64'd0);
    @(posedge clk); #1;
    check({tag, "_e2"}, out_valid, 64'd0);
    @(posedge clk); #1;
    check({tag, "_e3"}, out_valid, 64'd1);
    wait_drain();
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic  rand_done;
  int    run_len;
  int    base;

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_mant   = '0;
    in_cnt    = '0;
    in_nz     = 1'b0;
    out_ready = 1'b1;
    rand_done = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_out_sticky", out_sticky, 64'd0);
    check("rst_out_zero", out_zero, 64'd0);
    reset = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 64'd1);
    @(posedge clk); #1;

    // Latency plus the test-plan vectors
    latency_probe("lat", 48'h8000_0000_0000, 6'd47);
    run_one("c47_one", 48'h8000_0000_0000, 6'd47, 1'b1, 48'd1, 1'b0, 1'b0);
    run_one("c1_tie", 48'hC000_0000_0001, 6'd1, 1'b1, 48'h6000_0000_0000, 1'b1, 1'b0);
    run_one("c50", 48'hFFFF_FFFF_FFFF, 6'd50, 1'b1, 48'd0, 1'b1, 1'b1);
    run_one("nz0", 48'h1234_5678_9ABC, 6'd3, 1'b0, 48'd0, 1'b0, 1'b1);
    run_one("mant0", 48'd0, 6'd5, 1'b1, 48'd0, 1'b0, 1'b1);
    run_one("c0", 48'h8123_4567_89AB, 6'd0, 1'b1, 48'h8123_4567_89AB, 1'b0, 1'b0);
`ifdef LZD_DENORM_ROUND_EN
    run_one("c47_all", 48'hFFFF_FFFF_FFFF, 6'd47, 1'b1, 48'd2, 1'b1, 1'b0);
`else
    run_one("c47_all", 48'hFFFF_FFFF_FFFF, 6'd47, 1'b1, 48'd1, 1'b1, 1'b0);
`endif
    run_one("c48", 48'h8000_0000_0000, 6'd48, 1'b1, 48'd0, 1'b1, 1'b1);
    run_one("c63", 48'hFFFF_0000_0000, 6'd63, 1'b1, 48'd0, 1'b1, 1'b1);
    run_one("c17", 48'hF000_0000_0000, 6'd17, 1'b1, 48'h0000_7800_0000, 1'b0, 1'b0);

    // Back-to-back stream, cnt 0..9, out_ready held high
    run_len = 0;
    fork
      begin
        for (int i = 0; i < 10; i++) send(48'hA5A5_0000_0000 | 48'(i), 6'(i), 1'b1);
      end
      begin
        int n;
        n = 0;
        while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
        while (out_valid && run_len < 20) begin run_len++; @(posedge clk); #1; end
      end
    join
    check("stream_run", run_len, 64'd10);
    wait_drain();

    // Output stall with the pipe initially empty
    out_ready = 1'b0;
    base      = acc_cnt;
    fork
      begin
        for (int i = 0; i < 6; i++) send(48'h9000_0000_0000 + 48'(i * 7), 6'(i + 20), 1'b1);
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        check("stall_accepted", acc_cnt - base, 64'd3);
        check("stall_in_ready", in_ready, 64'd0);
        check("stall_out_valid", out_valid, 64'd1);
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // Randomised words with random backpressure
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          logic [63:0] r;
          logic [47:0] m;
          r = {$urandom, $urandom};
          m = ($urandom_range(0, 9) == 0) ? 48'd0 : {1'b1, r[46:0]};
          send(m, 6'($urandom_range(0, 63)), ($urandom_range(0, 7) != 0));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // Asynchronous reset while words are in flight
    for (int i = 0; i < 4; i++) send(48'hC000_0000_0000 + 48'(i), 6'(i), 1'b1);
    check("pre_rst_valid", out_valid, 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_valid", out_valid, 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 64'd1);
    @(posedge clk); #1;
    latency_probe("post_rst_lat", 48'hFEDC_BA98_7654, 6'd9);

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
